// File: rtl/gpio_irq.sv
// Wishbone-slave GPIO: PORT_NUM x PORT_WIDTH pins, 2-flop input sync, per-bit edge IRQs, W1C pending.
// Define GPIO_DEBOUNCE_EN to add a per-port input debouncer with DB_LIMIT at register 7.
module gpio_irq #(
  parameter int DATA_WIDTH      = 32,
  parameter int SEL_WIDTH       = 4,
  parameter int PORT_NUM        = 2,
  parameter int PORT_WIDTH      = 8,
  parameter int ADDR_PORT_WIDTH = 3,
  parameter int ADDR_REG_WIDTH  = 3,
  parameter int ADDR_WIDTH      = ADDR_PORT_WIDTH + ADDR_REG_WIDTH,
  parameter int DB_CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          sa_dat_i,
  input  logic [SEL_WIDTH-1:0]           sa_sel_i,
  input  logic [ADDR_WIDTH-1:0]          sa_addr_i,
  input  logic                           sa_stb_i,
  input  logic                           sa_we_i,
  output logic [DATA_WIDTH-1:0]          sa_dat_o,
  output logic                           sa_ack_o,
  inout  wire  [PORT_NUM*PORT_WIDTH-1:0] gpio_io,
  output logic                           irq_o
);

  localparam int NB = PORT_NUM * PORT_WIDTH;

  typedef enum logic [ADDR_REG_WIDTH-1:0] {
    REG_DIR  = 'd0,
    REG_WR   = 'd1,
    REG_RD   = 'd2,
    REG_IEN  = 'd3,
    REG_POL  = 'd4,
    REG_BOTH = 'd5,
    REG_PEND = 'd6,
    REG_AUX  = 'd7
  } reg_e;

  logic                  sa_ack_q;
  logic [DATA_WIDTH-1:0] sa_dat_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NB-1:0] dir_q, dir_d, wr_q, wr_d, ien_q, ien_d;
  logic [NB-1:0] pol_q, pol_d, both_q, both_d, pend_q, pend_d, clr;
  logic [NB-1:0] s1_q, s2_q, s3_q, sense, rise, fall, edge_hit;

  logic [ADDR_PORT_WIDTH-1:0] port_idx;
  reg_e                       reg_sel;
  logic                       access, wr_en;
  logic [DATA_WIDTH-1:0]      bmask;
  logic [PORT_WIDTH-1:0]      wmask, wdata;

`ifdef GPIO_DEBOUNCE_EN
  logic [PORT_NUM*DB_CNT_WIDTH-1:0] dbl_q, dbl_d, cnt_q, cnt_d;
  logic [NB-1:0]                    cand_q, db_q, db_d;
`else
  localparam int unused_db_cnt_width = DB_CNT_WIDTH;
`endif

  logic unused_bits;
  assign unused_bits = ^{sa_dat_i, bmask};

  assign port_idx = sa_addr_i[ADDR_WIDTH-1:ADDR_REG_WIDTH];
  assign reg_sel  = reg_e'(sa_addr_i[ADDR_REG_WIDTH-1:0]);
  assign access   = sa_stb_i & ~sa_ack_q;
  assign wr_en    = access & sa_we_i;
  assign wdata    = sa_dat_i[PORT_WIDTH-1:0];
  assign wmask    = bmask[PORT_WIDTH-1:0];

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) bmask[i] = sa_sel_i[i/8];
  end

  function automatic logic [PORT_WIDTH-1:0] merge(input logic [PORT_WIDTH-1:0] old_v,
                                                  input logic [PORT_WIDTH-1:0] m,
                                                  input logic [PORT_WIDTH-1:0] d);
    return (old_v & ~m) | (d & m);
  endfunction

  // Pins: drive only where DIR is set; the block samples its own outputs through the synchroniser.
  for (genvar b = 0; b < NB; b++) begin : g_pin
    assign gpio_io[b] = dir_q[b] ? wr_q[b] : 1'bz;
  end

  assign rise     = sense & ~s3_q;
  assign fall     = ~sense & s3_q;
  assign edge_hit = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    dir_d  = dir_q;
    wr_d   = wr_q;
    ien_d  = ien_q;
    pol_d  = pol_q;
    both_d = both_q;
    clr    = '0;
    rdata  = '0;
`ifdef GPIO_DEBOUNCE_EN
    dbl_d  = dbl_q;
`endif
    for (int p = 0; p < PORT_NUM; p++) begin
      if (port_idx == ADDR_PORT_WIDTH'(p)) begin
        case (reg_sel)
          REG_DIR: begin
            rdata = DATA_WIDTH'(dir_q[p*PORT_WIDTH +: PORT_WIDTH]);
            if (wr_en) dir_d[p*PORT_WIDTH +: PORT_WIDTH] = merge(dir_q[p*PORT_WIDTH +: PORT_WIDTH], wmask, wdata);
          end
          REG_WR: begin
            rdata = DATA_WIDTH'(wr_q[p*PORT_WIDTH +: PORT_WIDTH]);
            if (wr_en) wr_d[p*PORT_WIDTH +: PORT_WIDTH] = merge(wr_q[p*PORT_WIDTH +: PORT_WIDTH], wmask, wdata);
          end
          REG_RD: rdata = DATA_WIDTH'(sense[p*PORT_WIDTH +: PORT_WIDTH]);
          REG_IEN: begin
            rdata = DATA_WIDTH'(ien_q[p*PORT_WIDTH +: PORT_WIDTH]);
            if (wr_en) ien_d[p*PORT_WIDTH +: PORT_WIDTH] = merge(ien_q[p*PORT_WIDTH +: PORT_WIDTH], wmask, wdata);
          end
          REG_POL: begin
            rdata = DATA_WIDTH'(pol_q[p*PORT_WIDTH +: PORT_WIDTH]);
            if (wr_en) pol_d[p*PORT_WIDTH +: PORT_WIDTH] = merge(pol_q[p*PORT_WIDTH +: PORT_WIDTH], wmask, wdata);
          end
          REG_BOTH: begin
            rdata = DATA_WIDTH'(both_q[p*PORT_WIDTH +: PORT_WIDTH]);
            if (wr_en) both_d[p*PORT_WIDTH +: PORT_WIDTH] = merge(both_q[p*PORT_WIDTH +: PORT_WIDTH], wmask, wdata);
          end
          REG_PEND: begin
            rdata = DATA_WIDTH'(pend_q[p*PORT_WIDTH +: PORT_WIDTH]);
            if (wr_en) clr[p*PORT_WIDTH +: PORT_WIDTH] = wdata & wmask;
          end
`ifdef GPIO_DEBOUNCE_EN
          REG_AUX: begin
            rdata = DATA_WIDTH'(dbl_q[p*DB_CNT_WIDTH +: DB_CNT_WIDTH]);
            if (wr_en) dbl_d[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] =
                (dbl_q[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] & ~bmask[DB_CNT_WIDTH-1:0]) |
                (sa_dat_i[DB_CNT_WIDTH-1:0] & bmask[DB_CNT_WIDTH-1:0]);
          end
`endif
          default: ;
        endcase
      end
    end
    // A new edge in the same cycle as a clear keeps the bit set.
    pend_d = (pend_q & ~clr) | edge_hit;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_ack_q <= 1'b0;
      sa_dat_q <= '0;
      dir_q    <= '0;
      wr_q     <= '0;
      ien_q    <= '0;
      pol_q    <= '0;
      both_q   <= '0;
      pend_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      sa_ack_q <= sa_stb_i & ~sa_ack_q;
      if (access && !sa_we_i) sa_dat_q <= rdata;
      dir_q    <= dir_d;
      wr_q     <= wr_d;
      ien_q    <= ien_d;
      pol_q    <= pol_d;
      both_q   <= both_d;
      pend_q   <= pend_d;
      s1_q     <= gpio_io;
      s2_q     <= s1_q;
      s3_q     <= sense;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // db follows s2 once the next count equals DB_LIMIT, so DB_LIMIT=0 costs a single cycle.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (s2_q[p*PORT_WIDTH +: PORT_WIDTH] != cand_q[p*PORT_WIDTH +: PORT_WIDTH])
        cnt_d[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] = '0;
      else if (cnt_q[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] != '1)
        cnt_d[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] = cnt_q[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] + 1'b1;
      if (cnt_d[p*DB_CNT_WIDTH +: DB_CNT_WIDTH] == dbl_q[p*DB_CNT_WIDTH +: DB_CNT_WIDTH])
        db_d[p*PORT_WIDTH +: PORT_WIDTH] = s2_q[p*PORT_WIDTH +: PORT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbl_q  <= '0;
      cnt_q  <= '0;
      cand_q <= '0;
      db_q   <= '0;
    end else begin
      dbl_q  <= dbl_d;
      cnt_q  <= cnt_d;
      cand_q <= s2_q;
      db_q   <= db_d;
    end
  end

  assign sense = db_q;
`else
  assign sense = s2_q;
`endif

  assign sa_ack_o = sa_ack_q;
  assign sa_dat_o = sa_dat_q;
  assign irq_o    = |(pend_q & ien_q);

endmodule

// File: tb/tb_gpio_irq.sv
// Directed, table-driven bench for gpio_irq: register map, pin drive, edge IRQs, W1C, reset.
module tb_gpio_irq;

`ifdef GPIO_DEBOUNCE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [2:0] R_DIR = 3'd0, R_WR = 3'd1, R_RD = 3'd2, R_IEN = 3'd3;
  localparam logic [2:0] R_POL = 3'd4, R_BOTH = 3'd5, R_PEND = 3'd6, R_AUX = 3'd7;

  typedef struct {
    logic        we;
    logic [2:0]  port;
    logic [2:0]  rg;
    logic [31:0] data;
    logic [3:0]  sel;
    int          pre;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sa_dat_i;
  logic [3:0]  sa_sel_i;
  logic [5:0]  sa_addr_i;
  logic        sa_stb_i, sa_we_i;
  logic [31:0] sa_dat_o;
  logic        sa_ack_o, irq_o;
  wire  [15:0] gpio;
  logic [15:0] ext_en, ext_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar b = 0; b < 16; b++) begin : g_ext
    assign gpio[b] = ext_en[b] ? ext_val[b] : 1'bz;
  end

  gpio_irq dut (
    .clk       (clk),
    .reset     (reset),
    .sa_dat_i  (sa_dat_i),
    .sa_sel_i  (sa_sel_i),
    .sa_addr_i (sa_addr_i),
    .sa_stb_i  (sa_stb_i),
    .sa_we_i   (sa_we_i),
    .sa_dat_o  (sa_dat_o),
    .sa_ack_o  (sa_ack_o),
    .gpio_io   (gpio),
    .irq_o     (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [2:0] port, input logic [2:0] rg,
                     input logic [31:0] data, input logic [3:0] sel, output logic [31:0] rd);
    @(posedge clk); #1;
    check("ack_idle", {31'b0, sa_ack_o}, 32'd0);
    sa_stb_i  = 1'b1;
    sa_we_i   = we;
    sa_addr_i = {port, rg};
    sa_dat_i  = data;
    sa_sel_i  = sel;
    @(posedge clk); #1;
    check("ack", {31'b0, sa_ack_o}, 32'd1);
    rd       = sa_dat_o;
    sa_stb_i = 1'b0;
    sa_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] port, input logic [2:0] rg, input logic [31:0] data);
    logic [31:0] rd;
    bus(1'b1, port, rg, data, 4'hF, rd);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] port, input logic [2:0] rg,
                        input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, port, rg, 32'd0, 4'hF, rd);
    check(name, rd, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] port, input logic [2:0] rg,
                              input logic [31:0] data, input logic [3:0] sel, input int pre,
                              input logic [31:0] exp);
    vec_t v;
    v.we = we; v.port = port; v.rg = rg; v.data = data; v.sel = sel; v.pre = pre; v.exp = exp;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    logic [31:0] rd;
    repeat (v.pre) @(posedge clk);
    bus(v.we, v.port, v.rg, v.data, v.sel, rd);
    if (!v.we) check(tag, rd, v.exp);
  endtask

  task automatic flush_pend();
    repeat (6) @(posedge clk);
    wr(3'd0, R_PEND, 32'hFF);
    wr(3'd1, R_PEND, 32'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rst_vecs[$];
    vec_t rw_vecs[$];

    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 8; r++)
        rst_vecs.push_back(mk(1'b0, 3'(p), 3'(r), 32'd0, 4'hF, 0, 32'd0));

    rw_vecs.push_back(mk(1, 3'd0, R_DIR,  32'hFFFF_FFFF, 4'hF, 0, 0));
    rw_vecs.push_back(mk(1, 3'd0, R_WR,   32'h0000_00A5, 4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd0, R_RD,   0,             4'hF, 2, 32'hA5));
    rw_vecs.push_back(mk(0, 3'd0, R_DIR,  0,             4'hF, 0, 32'hFF));
    rw_vecs.push_back(mk(1, 3'd0, R_WR,   32'h0000_0000, 4'h0, 0, 0));
    rw_vecs.push_back(mk(0, 3'd0, R_WR,   0,             4'hF, 0, 32'hA5));
    rw_vecs.push_back(mk(1, 3'd0, R_WR,   32'h0000_5A00, 4'h2, 0, 0));
    rw_vecs.push_back(mk(0, 3'd0, R_WR,   0,             4'hF, 0, 32'hA5));
    rw_vecs.push_back(mk(1, 3'd0, R_WR,   32'hFFFF_FF3C, 4'h1, 0, 0));
    rw_vecs.push_back(mk(0, 3'd0, R_WR,   0,             4'hF, 0, 32'h3C));
    rw_vecs.push_back(mk(0, 3'd0, R_RD,   0,             4'hF, 2, 32'h3C));
    rw_vecs.push_back(mk(1, 3'd0, R_PEND, 32'hFF,        4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd0, R_PEND, 0,             4'hF, 0, 32'h00));
    rw_vecs.push_back(mk(1, 3'd0, R_WR,   32'h00,        4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd0, R_PEND, 0,             4'hF, 3, 32'h3C));
    rw_vecs.push_back(mk(0, 3'd0, R_AUX,  0,             4'hF, 0, 32'h00));
    rw_vecs.push_back(mk(1, 3'd5, R_DIR,  32'hFF,        4'hF, 0, 0));
    rw_vecs.push_back(mk(1, 3'd5, R_WR,   32'h77,        4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd5, R_DIR,  0,             4'hF, 0, 32'h00));
    rw_vecs.push_back(mk(0, 3'd1, R_DIR,  0,             4'hF, 0, 32'h00));
    rw_vecs.push_back(mk(0, 3'd1, R_WR,   0,             4'hF, 0, 32'h00));
    rw_vecs.push_back(mk(0, 3'd5, R_RD,   0,             4'hF, 0, 32'h00));
    rw_vecs.push_back(mk(1, 3'd1, R_POL,  32'h0F,        4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd1, R_POL,  0,             4'hF, 0, 32'h0F));
    rw_vecs.push_back(mk(1, 3'd1, R_IEN,  32'hFFFF_FF80, 4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd1, R_IEN,  0,             4'hF, 0, 32'h80));
    rw_vecs.push_back(mk(1, 3'd1, R_BOTH, 32'h80,        4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd1, R_BOTH, 0,             4'hF, 0, 32'h80));
    rw_vecs.push_back(mk(1, 3'd1, R_RD,   32'hFF,        4'hF, 0, 0));
    rw_vecs.push_back(mk(0, 3'd1, R_RD,   0,             4'hF, 0, 32'h5A));

    reset = 1'b1; sa_stb_i = 1'b0; sa_we_i = 1'b0;
    sa_addr_i = '0; sa_dat_i = '0; sa_sel_i = '0;
    ext_en = 16'hFFFF; ext_val = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ack", {31'b0, sa_ack_o}, 32'd0);
    check("rst_dat", sa_dat_o, 32'd0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);

    foreach (rst_vecs[i]) run(rst_vecs[i], $sformatf("rst_rd[%0d]", i));

    // Block must not drive after reset: external values come back intact, rising edges ignored.
    ext_val = 16'h5A3C;
    repeat (4) @(posedge clk);
    rd_chk("z_rd0", 3'd0, R_RD, 32'h3C);
    rd_chk("z_rd1", 3'd1, R_RD, 32'h5A);
    rd_chk("z_pend0", 3'd0, R_PEND, 32'h00);
    rd_chk("z_pend1", 3'd1, R_PEND, 32'h00);
    check("z_pins", {16'd0, gpio}, 32'h5A3C);

    ext_en = 16'hFF00;
    foreach (rw_vecs[i]) run(rw_vecs[i], $sformatf("rw[%0d]", i));
    check("irq_masked", {31'b0, irq_o}, 32'd0);

    ext_val[7:0] = 8'h00;
    ext_en = 16'hFFFF;
    wr(3'd0, R_DIR, 32'h00);
    flush_pend();
    rd_chk("flush_pend0", 3'd0, R_PEND, 32'h00);
    rd_chk("flush_pend1", 3'd1, R_PEND, 32'h00);

    // Rising edge on pins 0 and 1, only bit 0 enabled: irq after the 3rd edge.
    wr(3'd0, R_IEN, 32'h01);
    wr(3'd0, R_POL, 32'h03);
    check("irq_pre", {31'b0, irq_o}, 32'd0);
    @(posedge clk); #1 ext_val[1:0] = 2'b11;
    for (int k = 1; k <= 3 + EXTRA; k++) begin
      @(posedge clk); #1;
      check($sformatf("irq_lat%0d", k), {31'b0, irq_o}, (k == 3 + EXTRA) ? 32'd1 : 32'd0);
    end
    rd_chk("pend0_set", 3'd0, R_PEND, 32'h03);
    wr(3'd0, R_PEND, 32'h01);
    check("irq_w1c", {31'b0, irq_o}, 32'd0);
    rd_chk("pend0_left", 3'd0, R_PEND, 32'h02);

    // Both-edge on pin 15; the falling edge lands on the same clock as its W1C.
    ext_val[15] = 1'b1;
    repeat (6) @(posedge clk);
    rd_chk("pend1_rise", 3'd1, R_PEND, 32'h80);
    check("irq_p1", {31'b0, irq_o}, 32'd1);
    @(posedge clk); #1 ext_val[15] = 1'b0;
    @(posedge clk);
    repeat (EXTRA) @(posedge clk);
    wr(3'd1, R_PEND, 32'h80);
    check("irq_setwins", {31'b0, irq_o}, 32'd1);
    rd_chk("pend1_setwins", 3'd1, R_PEND, 32'h80);
    wr(3'd1, R_PEND, 32'h80);
    check("irq_clr1", {31'b0, irq_o}, 32'd0);
    rd_chk("pend1_clr", 3'd1, R_PEND, 32'h00);

`ifdef GPIO_DEBOUNCE_EN
    ext_val[1:0] = 2'b00;
    flush_pend();
    wr(3'd0, R_AUX, 32'd10);
    rd_chk("db_limit", 3'd0, R_AUX, 32'd10);
    @(posedge clk); #1 ext_val[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 ext_val[0] = 1'b0;
    repeat (20) @(posedge clk);
    rd_chk("db_glitch_pend", 3'd0, R_PEND, 32'h00);
    rd_chk("db_glitch_rd", 3'd0, R_RD, 32'h00);
    @(posedge clk); #1 ext_val[0] = 1'b1;
    repeat (14) @(posedge clk);
    rd_chk("db_stable_rd", 3'd0, R_RD, 32'h01);
    rd_chk("db_stable_pend", 3'd0, R_PEND, 32'h01);
`endif

    // Reset together with a write strobe: no ack, write discarded.
    @(posedge clk); #1;
    reset = 1'b1; sa_stb_i = 1'b1; sa_we_i = 1'b1;
    sa_addr_i = {3'd1, R_WR}; sa_dat_i = 32'h77; sa_sel_i = 4'hF;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'b0, sa_ack_o}, 32'd0);
    reset = 1'b0; sa_stb_i = 1'b0; sa_we_i = 1'b0;
    rd_chk("rst_mid_wr1", 3'd1, R_WR, 32'h00);
    rd_chk("rst_mid_pend0", 3'd0, R_PEND, 32'h00);
    check("rst_mid_irq", {31'b0, irq_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Wishbone-slave GPIO block for MPSoC tiles. Provides PORT_NUM bidirectional ports, each PORT_WIDTH bits wide.
- Adds behaviour the previous GPIO did not have:
  - two-flop input synchronisers;
  - per-bit edge-detect interrupts with selectable polarity or both-edge detection;
  - write-1-to-clear pending register;
  - a single aggregated interrupt line to the tile's interrupt controller.

Parameters:
- DATA_WIDTH, 32, Wishbone data width; must be >= PORT_WIDTH.
- SEL_WIDTH, 4, byte-select width (DATA_WIDTH/8).
- PORT_NUM, 2, number of ports, 1..2^ADDR_PORT_WIDTH.
- PORT_WIDTH, 8, bits per port, 1..DATA_WIDTH.
- ADDR_PORT_WIDTH, 3, port-select address bits.
- ADDR_REG_WIDTH, 3, register-select address bits.
- ADDR_WIDTH, ADDR_PORT_WIDTH+ADDR_REG_WIDTH, total word address width.
- DB_CNT_WIDTH, 16, debounce counter width; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sa_dat_i  input  DATA_WIDTH  write data.
- sa_sel_i  input  SEL_WIDTH  byte enables, applied to writes.
- sa_addr_i  input  ADDR_WIDTH  word address, {port, reg}.
- sa_stb_i  input  1  strobe.
- sa_we_i  input  1  write enable.
- sa_dat_o  output  DATA_WIDTH  registered read data.
- sa_ack_o  output  1  acknowledge.
- gpio_io  inout  PORT_NUM*PORT_WIDTH  pins; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH].
- irq_o  output  1  aggregated interrupt.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. No async resets.
- Reset values:
  - all registers and synchroniser/edge flops = 0;
  - sa_ack_o = 0, sa_dat_o = 0, irq_o = 0;
  - all pins tri-stated.
- Register map per port (reg index):
  - 0 DIR: RW, 1 = drive.
  - 1 WRITE: RW, output value.
  - 2 READ: RO, synchronised pin value.
  - 3 IRQ_EN: RW.
  - 4 IRQ_POL: RW, 1 = rising, 0 = falling.
  - 5 IRQ_BOTH: RW, 1 = both edges; overrides POL.
  - 6 IRQ_PEND: read returns pending bits; write 1 clears a bit.
  - 7: reserved, reads 0, writes ignored.
- Data is right-aligned; upper DATA_WIDTH-PORT_WIDTH read bits are 0.
- Handshake:
  - sa_ack_o <= sa_stb_i & ~sa_ack_o. Exactly one cycle after stb, then low for one cycle; back-to-back accesses ack every other cycle.
  - A write takes effect on the clock edge that asserts ack: condition sa_stb_i & sa_we_i & ~sa_ack_o. It is applied once per transaction, masked per byte by sa_sel_i.
  - Read data is loaded into sa_dat_o on the same edge and is valid while ack = 1. sa_dat_o holds its value otherwise.
- A port index >= PORT_NUM reads 0 and ignores writes; it is still acked.
- Pin drive: gpio_io[b] = DIR[b] ? WRITE[b] : Z, evaluated combinationally from the registers.
- Input path and edge detection:
  - Pins pass through s1 -> s2 (synchroniser) -> s3 (previous value).
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - edge = BOTH ? (rise|fall) : (POL ? rise : fall).
- Pending update, per bit, each cycle: PEND <= (PEND & ~clear_w1c) | edge.
  - A new edge in the same cycle as a W1C clear leaves PEND = 1 (set wins).
  - Edges set PEND even when IRQ_EN = 0.
- irq_o = OR over all bits of (PEND & IRQ_EN), built from flops only, no combinational input path.
- Latency: a pin change settled before edge 1 gives:
  - s2 updated after edge 2 (READ shows the new value);
  - PEND set after edge 3;
  - irq_o high after edge 3.
- Output pins driven by the block itself are also sampled through the same path, so self-loopback generates edges.
- Reset asserted mid-transaction: ack is dropped the next cycle, and any pending write in that cycle is discarded.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- When defined:
  - Adds per-port register 7 DB_LIMIT (RW, DB_CNT_WIDTH bits, reset 0).
  - Adds a per-port counter and a debounced value db.
  - If s2 != db candidate, the candidate is reloaded and the counter reset to 0.
  - Otherwise the counter increments, saturating. When counter == DB_LIMIT, db <= candidate.
  - READ and edge detection use db in place of s2; s3 tracks db.
  - DB_LIMIT = 0 gives one extra cycle of latency versus the undefined case.
- When undefined: register 7 is reserved and no counters are synthesised.

Test Plan:
- Reset, then read every register of port 0 and port 1 -> all return 0x0; gpio_io is all Z; irq_o = 0; every access acked 1 cycle after stb.
- Write DIR0 = 0xFF, WRITE0 = 0xA5 -> gpio_io[7:0] = 0xA5; READ0 returns 0xA5 after ≥2 cycles; write with sa_sel_i = 0 leaves WRITE0 unchanged.
- IRQ_EN0 = 0x01, POL0 = 1, external pin0 driven 0->1 -> PEND0 = 0x01 and irq_o = 1 on the 3rd edge. Write PEND0 = 0x01 -> irq_o = 0 next cycle.
- BOTH1 = 0x80, IRQ_EN1 = 0x80; toggle pin15 1->0 in the same cycle a W1C of PEND1 = 0x80 lands -> PEND1 stays 0x80 and irq_o stays 1.
- Access port 5 with PORT_NUM = 2 -> read 0x0, write ignored, ack still returned. Assert reset during stb -> ack low next cycle, no register changes.
- GPIO_DEBOUNCE_EN with DB_LIMIT0 = 10: a 5-cycle glitch on pin0 gives no PEND and READ unchanged; a stable 1 for 12 cycles updates READ0 and sets PEND0.
